div_share_arbiter: RTL

DIV_SHARE_ARBITER -- requirements
Module: div_share_arbiter

---
 rtl/div_arb_pkg.sv | 28 ++
 rtl/rr_pick.sv | 50 +++++
 rtl/div_share_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/div_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_arb_pkg
//  Purpose  : Shared definitions for the divider-sharing arbiter: the arbiter
//             FSM state type, the default requester count and data width,
//             and a helper that sizes requester-index fields.
//  Contents : N_REQ_DEFAULT, WIDTH_DEFAULT, state_t, idx_width()
//  Revision : 1.0 - initial release
// ============================================================================
package div_arb_pkg;

   localparam int N_REQ_DEFAULT = 4;
   localparam int WIDTH_DEFAULT = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Width of a field able to hold a requester index 0..n-1 (at least 1 bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : div_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin winner selection. Searches the
//             request vector starting at (last_grant+1) mod N_REQ and wraps
//             upward; the first set request wins.
//  Ports    : req        in  N_REQ  request vector
//             last_grant in  IDXW   index of the previously served requester
//             grant      out N_REQ  one-hot winner (zero if no request)
//             grant_idx  out IDXW   index of the winner
//             valid      out 1      at least one request present
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick
   import div_arb_pkg::*;
#(
   parameter  int N_REQ = N_REQ_DEFAULT,
   localparam int IDXW  = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDXW-1:0]  last_grant,
   output logic [N_REQ-1:0] grant,
   output logic [IDXW-1:0]  grant_idx,
   output logic             valid
);

   int cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      valid     = 1'b0;
      cand      = 0;
      // Offsets 1..N_REQ visit every requester once, the last one being
      // last_grant itself, so the previous winner has lowest priority.
      for (int off = 1; off <= N_REQ; off++) begin
         cand = int'(last_grant) + off;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         if (!valid && req[cand[IDXW-1:0]]) begin
            grant[cand[IDXW-1:0]] = 1'b1;
            grant_idx             = cand[IDXW-1:0];
            valid                 = 1'b1;
         end
      end
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/div_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : div_share_arbiter
//  Purpose  : Shares one sequential divider among N_REQ requesters. A winner
//             is chosen round-robin in S_IDLE, its operands are latched, the
//             divider is started (S_ISSUE), the result is awaited (S_WAIT)
//             and returned with a one-cycle done pulse (S_DONE).
//  Ports    : i_clk, i_rst (async, active-high)
//             i_req[N_REQ], i_dividend/i_divisor[N_REQ*WIDTH] requester side
//             o_grant, o_done, o_quotient, o_remain, o_busy, o_dbz
//             o_div_start, o_div_dividend, o_div_divisor  -> divider
//             i_div_done, i_div_quotient, i_div_remain    <- divider
//  Config   : DIV_ZERO_BYPASS_EN - when defined, divide-by-zero jobs are
//             answered locally (quotient all-ones, remain = dividend,
//             o_dbz = 1) without starting the divider. Otherwise o_dbz is 0.
//  Revision : 1.0 - initial release
// ============================================================================
module div_share_arbiter
   import div_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEFAULT,
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [N_REQ-1:0]       i_req,
   input  logic [N_REQ*WIDTH-1:0] i_dividend,
   input  logic [N_REQ*WIDTH-1:0] i_divisor,
   output logic [N_REQ-1:0]       o_grant,
   output logic [N_REQ-1:0]       o_done,
   output logic [WIDTH-1:0]       o_quotient,
   output logic [WIDTH-1:0]       o_remain,
   output logic                   o_busy,
   output logic                   o_dbz,
   output logic                   o_div_start,
   output logic [WIDTH-1:0]       o_div_dividend,
   output logic [WIDTH-1:0]       o_div_divisor,
   input  logic                   i_div_done,
   input  logic [WIDTH-1:0]       i_div_quotient,
   input  logic [WIDTH-1:0]       i_div_remain
);

   localparam int IDXW = idx_width(N_REQ);

   state_t            state;
   logic [IDXW-1:0]   last_grant;
   logic [IDXW-1:0]   grant_idx;
   logic [N_REQ-1:0]  grant_reg;
   logic [N_REQ-1:0]  done_reg;
   logic [WIDTH-1:0]  quotient_reg;
   logic [WIDTH-1:0]  remain_reg;
   logic              busy_reg;
   logic              start_reg;
   logic [WIDTH-1:0]  dividend_reg;
   logic [WIDTH-1:0]  divisor_reg;

   logic [N_REQ-1:0]  pick_grant;
   logic [IDXW-1:0]   pick_idx;
   logic              pick_valid;
   logic [WIDTH-1:0]  sel_dividend;
   logic [WIDTH-1:0]  sel_divisor;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .req        (i_req),
      .last_grant (last_grant),
      .grant      (pick_grant),
      .grant_idx  (pick_idx),
      .valid      (pick_valid)
   );

   // Operands of the prospective winner; only latched on the grant cycle.
   always_comb begin
      sel_dividend = '0;
      sel_divisor  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (pick_grant[k]) begin
            sel_dividend = i_dividend[k*WIDTH +: WIDTH];
            sel_divisor  = i_divisor[k*WIDTH +: WIDTH];
         end
      end
   end

`ifdef DIV_ZERO_BYPASS_EN
   logic dbz_reg;
   assign o_dbz = dbz_reg;
`else
   assign o_dbz = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= S_IDLE;
         last_grant   <= IDXW'(N_REQ - 1);
         grant_idx    <= '0;
         grant_reg    <= '0;
         done_reg     <= '0;
         quotient_reg <= '0;
         remain_reg   <= '0;
         busy_reg     <= 1'b0;
         start_reg    <= 1'b0;
         dividend_reg <= '0;
         divisor_reg  <= '0;
`ifdef DIV_ZERO_BYPASS_EN
         dbz_reg      <= 1'b0;
`endif
      end else begin
         // Pulse outputs default low; they are raised only on entry to the
         // state that owns them, so each lasts exactly one cycle.
         done_reg  <= '0;
         start_reg <= 1'b0;

         case (state)
            S_IDLE: begin
               if (pick_valid) begin
                  grant_reg    <= pick_grant;
                  grant_idx    <= pick_idx;
                  dividend_reg <= sel_dividend;
                  divisor_reg  <= sel_divisor;
                  busy_reg     <= 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
                  if (sel_divisor == '0) begin
                     // Result is known immediately; the divider is never
                     // started and the done pulse appears next cycle.
                     quotient_reg <= '1;
                     remain_reg   <= sel_dividend;
                     dbz_reg      <= 1'b1;
                     done_reg     <= pick_grant;
                     state        <= S_DONE;
                  end else begin
                     start_reg <= 1'b1;
                     state     <= S_ISSUE;
                  end
`else
                  start_reg <= 1'b1;
                  state     <= S_ISSUE;
`endif
               end
            end

            S_ISSUE: begin
               state <= S_WAIT;
            end

            S_WAIT: begin
               if (i_div_done) begin
                  quotient_reg <= i_div_quotient;
                  remain_reg   <= i_div_remain;
`ifdef DIV_ZERO_BYPASS_EN
                  dbz_reg      <= 1'b0;
`endif
                  done_reg     <= grant_reg;
                  state        <= S_DONE;
               end
            end

            S_DONE: begin
               last_grant <= grant_idx;
               grant_reg  <= '0;
               busy_reg   <= 1'b0;
               state      <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_grant        = grant_reg;
   assign o_done         = done_reg;
   assign o_quotient     = quotient_reg;
   assign o_remain       = remain_reg;
   assign o_busy         = busy_reg;
   assign o_div_start    = start_reg;
   assign o_div_dividend = dividend_reg;
   assign o_div_divisor  = divisor_reg;

endmodule : div_share_arbiter
`default_nettype wire
